// File: rtl/counter_modn.sv
// counter_modn -- modulo-N up/down counter with terminal count and
// divided-frequency output.
//
// Counts through 0..MODULUS-1 in either direction, wrapping at the ends.
// tc flags the last value in the current direction so that stages can be
// cascaded by tying the next stage's enable to tc. F is high for the upper
// half of the count range, which gives fclock/MODULUS when counting freely.
//
// Configuration macro: COUNTER_MODN_LOAD_EN
//   defined   -> load / load_value are honoured, and load has priority over
//                counting. A load_value above MODULUS-1 is clamped.
//   undefined -> load / load_value are present but ignored everywhere,
//                including in tc.
//
// Parameters:
//   MODULUS    count sequence length, 2..65536
//   WIDTH      counter width, $clog2(MODULUS) (not overridable)
// Ports:
//   clock      in   system clock, rising edge
//   clearn     in   asynchronous active-low clear
//   enable     in   count enable
//   down       in   0 = count up, 1 = count down
//   load       in   synchronous load strobe
//   load_value in   value to load (WIDTH bits)
//   count      out  current count, registered (WIDTH bits)
//   tc         out  terminal count, combinational
//   F          out  divided-frequency output, registered
module counter_modn #(
   parameter int MODULUS = 8,
   localparam int WIDTH = $clog2(MODULUS)
) (
   input  logic             clock,
   input  logic             clearn,
   input  logic             enable,
   input  logic             down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             F
);

   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] HALF_COUNT = WIDTH'(MODULUS / 2);
   localparam logic [WIDTH-1:0] ZERO_COUNT = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_COUNT = WIDTH'(1'b1);

   logic [WIDTH-1:0] count_r;
   logic             f_r;
   logic [WIDTH-1:0] next_count_s;
   logic             load_eff_s;
   logic [WIDTH-1:0] load_data_s;

   // Increment with wrap from the top of the range back to zero.
   function automatic logic [WIDTH-1:0] count_inc(input logic [WIDTH-1:0] c);
      if (c == MAX_COUNT) begin
         return ZERO_COUNT;
      end else begin
         return c + ONE_COUNT;
      end
   endfunction

   // Decrement with wrap from zero up to the top of the range.
   function automatic logic [WIDTH-1:0] count_dec(input logic [WIDTH-1:0] c);
      if (c == ZERO_COUNT) begin
         return MAX_COUNT;
      end else begin
         return c - ONE_COUNT;
      end
   endfunction

`ifdef COUNTER_MODN_LOAD_EN
   // Out-of-range load values saturate so the count never leaves the range.
   function automatic logic [WIDTH-1:0] load_clamp(input logic [WIDTH-1:0] v);
      if (v > MAX_COUNT) begin
         return MAX_COUNT;
      end else begin
         return v;
      end
   endfunction

   assign load_eff_s  = load;
   assign load_data_s = load_clamp(load_value);
`else
   // Load path is compiled out; the ports are kept but sunk here.
   logic unused_load_s;
   assign unused_load_s = ^{load, load_value};
   assign load_eff_s    = 1'b0;
   assign load_data_s   = ZERO_COUNT;
`endif

   // Next-count selection: load first, then counting, otherwise hold.
   always_comb begin
      next_count_s = count_r;
      if (load_eff_s) begin
         next_count_s = load_data_s;
      end else if (enable) begin
         if (down) begin
            next_count_s = count_dec(count_r);
         end else begin
            next_count_s = count_inc(count_r);
         end
      end else begin
         next_count_s = count_r;
      end
   end

   // Count and F registers. F is derived from the new count so the two
   // always change on the same edge and F simply holds when count holds.
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         count_r <= ZERO_COUNT;
         f_r     <= 1'b0;
      end else begin
         count_r <= next_count_s;
         f_r     <= (next_count_s >= HALF_COUNT);
      end
   end

   // tc is deliberately combinational so a downstream enable sees it in the
   // same cycle that this stage wraps.
   assign tc    = enable & ~load_eff_s &
                  (down ? (count_r == ZERO_COUNT) : (count_r == MAX_COUNT));
   assign count = count_r;
   assign F     = f_r;

endmodule

// File: tb/tb_counter_modn.sv
// tb_counter_modn -- self-checking bench for counter_modn.
// Instances: MODULUS=8, MODULUS=10, and a two-stage MODULUS=8 cascade.
// Expected values come from an arithmetic reference model (integers with
// modulo arithmetic and a min() clamp). The load behaviour expected by the
// model follows COUNTER_MODN_LOAD_EN, so the bench suits either build.
module tb_counter_modn;

   logic       clock;
   logic       clearn;

   logic       en8, dn8, ld8;
   logic [2:0] lv8;
   logic [2:0] cnt8;
   logic       tc8, f8;

   logic       en10, dn10, ld10;
   logic [3:0] lv10;
   logic [3:0] cnt10;
   logic       tc10, f10;

   logic       cen;
   logic [2:0] c0cnt, c1cnt;
   logic       c0tc, c0f, c1tc, c1f;

   int checks = 0;
   int errors = 0;

   int m8, m10, mc;

   counter_modn #(.MODULUS(8)) dut8 (
      .clock(clock), .clearn(clearn), .enable(en8), .down(dn8),
      .load(ld8), .load_value(lv8), .count(cnt8), .tc(tc8), .F(f8));

   counter_modn #(.MODULUS(10)) dut10 (
      .clock(clock), .clearn(clearn), .enable(en10), .down(dn10),
      .load(ld10), .load_value(lv10), .count(cnt10), .tc(tc10), .F(f10));

   counter_modn #(.MODULUS(8)) stage0 (
      .clock(clock), .clearn(clearn), .enable(cen), .down(1'b0),
      .load(1'b0), .load_value(3'd0), .count(c0cnt), .tc(c0tc), .F(c0f));

   counter_modn #(.MODULUS(8)) stage1 (
      .clock(clock), .clearn(clearn), .enable(c0tc), .down(1'b0),
      .load(1'b0), .load_value(3'd0), .count(c1cnt), .tc(c1tc), .F(c1f));

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit load_active(input bit ld);
`ifdef COUNTER_MODN_LOAD_EN
      return ld;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int model_next(input int c, input int m, input bit en,
                                     input bit dn, input bit ld, input int lv);
      if (load_active(ld)) return (lv > m - 1) ? m - 1 : lv;
      if (!en) return c;
      return dn ? (c + m - 1) % m : (c + 1) % m;
   endfunction

   function automatic int model_tc(input int c, input int m, input bit en,
                                   input bit dn, input bit ld);
      if (!en || load_active(ld)) return 0;
      return dn ? int'(c == 0) : int'(c == m - 1);
   endfunction

   task automatic check_all();
      check("cnt8", cnt8, m8);
      check("f8", f8, int'(m8 >= 4));
      check("tc8", tc8, model_tc(m8, 8, en8, dn8, ld8));
      check("cnt10", cnt10, m10);
      check("f10", f10, int'(m10 >= 5));
      check("tc10", tc10, model_tc(m10, 10, en10, dn10, ld10));
      check("c0cnt", c0cnt, mc % 8);
      check("c1cnt", c1cnt, mc / 8);
      check("c0tc", c0tc, int'(cen && (mc % 8 == 7)));
      check("c1tc", c1tc, int'(cen && (mc == 63)));
      check("c1f", c1f, int'(mc / 8 >= 4));
   endtask

   // Called just after a rising edge with the next inputs already applied.
   task automatic cycle();
      int n8, n10, nc;
      #1;
      check_all();
      n8  = model_next(m8, 8, en8, dn8, ld8, int'(lv8));
      n10 = model_next(m10, 10, en10, dn10, ld10, int'(lv10));
      nc  = cen ? (mc + 1) % 64 : mc;
      @(posedge clock);
      m8 = n8; m10 = n10; mc = nc;
      #1;
   endtask

   initial begin
      int guard;
      clearn = 1'b0;
      en8 = 1'b1; dn8 = 1'b0; ld8 = 1'b0; lv8 = 3'd0;
      en10 = 1'b1; dn10 = 1'b1; ld10 = 1'b0; lv10 = 4'd0;
      cen = 1'b1;
      m8 = 0; m10 = 0; mc = 0;

      // Reset state: tc10 must be 1 (enable, down, count 0) even in reset.
      #2;
      check("rst_cnt8", cnt8, 0);
      check("rst_f8", f8, 0);
      check("rst_tc10", tc10, 1);
      check("rst_cnt10", cnt10, 0);
      @(posedge clock);
      @(posedge clock);
      #1;
      clearn = 1'b1;

      // Up count on dut8, down count on dut10, cascade free-running.
      for (int i = 0; i < 64; i++) cycle();

      // Asynchronous clear for half a clock while dut8 shows 5.
      guard = 0;
      while (m8 != 5 && guard < 20) begin
         cycle();
         guard++;
      end
      check("reach5", m8, 5);
      clearn = 1'b0;
      #1;
      check("aclr_cnt8", cnt8, 0);
      check("aclr_f8", f8, 0);
      check("aclr_cnt10", cnt10, 0);
      check("aclr_c1cnt", c1cnt, 0);
      #4;
      clearn = 1'b1;
      m8 = 0; m10 = 0; mc = 0;
      for (int i = 0; i < 4; i++) cycle();

      // Load scenarios: dut8 held at 2, dut10 loaded with 13 then 4.
      guard = 0;
      while (m8 != 2 && guard < 20) begin
         cycle();
         guard++;
      end
      check("reach2", m8, 2);
      en8 = 1'b0; ld8 = 1'b1; lv8 = 3'd3;
      en10 = 1'b1; dn10 = 1'b0; ld10 = 1'b1; lv10 = 4'd13;
      cycle();
      en8 = 1'b1;
      en10 = 1'b0; lv10 = 4'd4;
      cycle();
      ld8 = 1'b0; ld10 = 1'b0;
      cycle();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         en8  = 1'($urandom_range(0, 3) != 0);
         dn8  = 1'($urandom_range(0, 1));
         ld8  = 1'($urandom_range(0, 7) == 0);
         lv8  = 3'($urandom);
         en10 = 1'($urandom_range(0, 3) != 0);
         dn10 = 1'($urandom_range(0, 1));
         ld10 = 1'($urandom_range(0, 7) == 0);
         lv10 = 4'($urandom);
         cen  = 1'($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/counter_modn.md
COUNTER_MODN -- requirements
Module: counter_modn

Interface
REQ-001 The block SHALL have parameter MODULUS, default 8, meaning the count sequence length; legal values 2..65536.
REQ-002 The block SHALL have localparam WIDTH = $clog2(MODULUS), meaning the counter width in bits, not overridable.
REQ-003 The block SHALL have port clock  input  1  system clock, rising-edge active.
REQ-004 The block SHALL have port clearn  input  1  asynchronous active-low reset/clear.
REQ-005 The block SHALL have port enable  input  1  count enable, sampled at the rising edge of clock.
REQ-006 The block SHALL have port down  input  1  direction: 0 counts up, 1 counts down.
REQ-007 The block SHALL have port load  input  1  synchronous load strobe.
REQ-008 The block SHALL have port load_value  input  WIDTH  value to load.
REQ-009 The block SHALL have port count  output  WIDTH  current count, registered.
REQ-010 The block SHALL have port tc  output  1  terminal-count flag for cascading, combinational.
REQ-011 The block SHALL have port F  output  1  divided-frequency output, registered.

Function
REQ-012 The block SHALL use one clock, clock, and an asynchronous active-low reset, clearn.
REQ-013 When enable=1, down=0 and load=0, the block SHALL update count on each rising edge from MODULUS-1 to 0, otherwise to count+1.
REQ-014 When enable=1, down=1 and load=0, the block SHALL update count on each rising edge from 0 to MODULUS-1, otherwise to count-1.
REQ-015 When enable=0 and load=0, the block SHALL hold count and F unchanged.
REQ-016 When load=1, the block SHALL set count to load_value on the rising edge, regardless of enable or down; load has priority over counting.
REQ-017 When load=1 and load_value >= MODULUS, the block SHALL set count to MODULUS-1 (clamp); count SHALL never leave 0..MODULUS-1.
REQ-018 The block SHALL drive tc = enable & ~load & (down ? count==0 : count==MODULUS-1), with zero latency, so that a downstream stage's enable can be tied to tc.
REQ-019 The block SHALL update F on the same edge as count, with F = (new count >= MODULUS/2) using integer division; for MODULUS=8, F is high for counts 4..7, giving a 50% duty cycle at fclock/8 when enabled continuously.
REQ-020 A change of down SHALL take effect at the next rising edge; there SHALL be no skipped or repeated value apart from the reversal itself.
REQ-021 For MODULUS not a power of two, codes from MODULUS to 2^WIDTH-1 SHALL be unreachable, and the wrap points SHALL be exactly those of REQ-013/014.

Reset
REQ-022 While clearn=0, the block SHALL immediately force count=0 and F=0, independent of clock; tc then follows REQ-018 (1 only if enable=1, load=0 and down=1).
REQ-023 When clearn is asserted mid-sequence or during a load, the block SHALL abandon the operation; no state survives.
REQ-024 On clearn deassertion, the first count change SHALL occur at the first rising edge with clearn=1 and enable=1 or load=1.

Configuration
REQ-025 When macro COUNTER_MODN_LOAD_EN is defined, the block SHALL implement load and load_value per REQ-016/017.
REQ-026 When COUNTER_MODN_LOAD_EN is undefined, the block SHALL keep the load and load_value ports but ignore them; counting SHALL behave as if load=0, including in tc.

Verification
REQ-027 The bench SHALL drive MODULUS=8, reset, enable=1, down=0 for 16 clocks -> count 0,1..7,0..7; tc high while count=7; F low for counts 0..3 and high for counts 4..7.
REQ-028 The bench SHALL drive MODULUS=10, enable=1, down=1 from reset -> count 0,9,8,...,0; tc high while count=0; F high for counts 5..9.
REQ-029 The bench SHALL run MODULUS=10 with COUNTER_MODN_LOAD_EN: load=1, load_value=13 -> count=9; load=1 with enable=0 and load_value=4 -> count=4; tc=0 in both load cycles.
REQ-030 The bench SHALL drive MODULUS=8 counting up, pull clearn low for 0.5 clock mid-cycle at count=5 -> count=0 and F=0 without waiting for an edge; counting resumes 1,2,... after release.
REQ-031 The bench SHALL cascade two MODULUS=8 instances, with the second stage's enable tied to the first stage's tc, for 64 clocks -> second count increments once per 8 clocks, and both tc are high together only at combined count 63.
REQ-032 The bench SHALL run without COUNTER_MODN_LOAD_EN: load=1, load_value=3 at count=2 -> next count=3 by counting, not by load; with enable=0 -> count stays at 2.
